// File: rtl/coin_acceptor_pkg.sv
// Shared definitions for the coin acceptor and the downstream vending FSM:
// acceptor state encoding and the coin codes presented on the coin bus.
package coin_acceptor_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StQual,
    StEmit,
    StReject,
    StRelease
  } state_e;

  localparam logic [1:0] COIN_NONE   = 2'b00;
  localparam logic [1:0] COIN_NICKEL = 2'b01;
  localparam logic [1:0] COIN_DIME   = 2'b10;

  function automatic logic [1:0] coin_code(input logic is_dime);
    return is_dime ? COIN_DIME : COIN_NICKEL;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous sensor line.
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces nickel/dime sensors, emits one coin or reject event per
// insertion, waits for a clean release, and flags sensors stuck high as a jam.
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int unsigned DEBOUNCE  = 4,
  parameter int unsigned JAM_LIMIT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nickel_in,
  input  logic       dime_in,
  input  logic       enable,
  output logic [1:0] coin,
  output logic       reject,
  output logic       jam,
  output logic       busy
);

  localparam logic [3:0] DebLast = 4'(DEBOUNCE);
  localparam logic [7:0] JamMax  = 8'(JAM_LIMIT);

  logic nickel_s;
  logic dime_s;

  sync2 u_sync_nickel (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (nickel_in),
    .q_o    (nickel_s)
  );

  sync2 u_sync_dime (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (dime_in),
    .q_o    (dime_s)
  );

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sel_dime_q, sel_dime_d;
  logic [7:0] jam_cnt_q, jam_cnt_d;
  logic [1:0] coin_q, coin_d;
  logic       reject_q, reject_d;
  logic       jam_q, jam_d;
  logic       latched_s;
  logic       other_s;
  logic       any_s;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_dime_d = sel_dime_q;
    coin_d     = COIN_NONE;
    reject_d   = 1'b0;
    jam_cnt_d  = jam_cnt_q;

    latched_s = sel_dime_q ? dime_s : nickel_s;
    other_s   = sel_dime_q ? nickel_s : dime_s;
    any_s     = nickel_s | dime_s;

    unique case (state_q)
      StIdle: begin
        if (nickel_s && dime_s) begin
          state_d  = StReject;
          reject_d = 1'b1;
        end else if (any_s) begin
          state_d    = StQual;
          sel_dime_d = dime_s;
          cnt_d      = 4'd1;
        end
      end
      StQual: begin
        if (other_s) begin
          state_d  = StReject;
          reject_d = 1'b1;
        end else if (!latched_s) begin
          state_d = StIdle;
        end else if (cnt_q == DebLast) begin
          // Enable only matters on the cycle qualification completes.
          if (enable) begin
            state_d = StEmit;
            coin_d  = coin_code(sel_dime_q);
          end else begin
            state_d  = StReject;
            reject_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StEmit: begin
        state_d = StRelease;
        cnt_d   = 4'd0;
      end
      StReject: begin
        state_d = StRelease;
        cnt_d   = 4'd0;
      end
      StRelease: begin
        if (any_s) begin
          cnt_d = 4'd0;
        end else if (cnt_q == DebLast - 4'd1) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase

    if (state_d == StIdle) begin
      jam_cnt_d = 8'd0;
    end else if (state_q == StRelease && any_s && jam_cnt_q != JamMax) begin
      jam_cnt_d = jam_cnt_q + 8'd1;
    end
    jam_d = (jam_cnt_d == JamMax);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      sel_dime_q <= 1'b0;
      jam_cnt_q  <= 8'd0;
      coin_q     <= COIN_NONE;
      reject_q   <= 1'b0;
      jam_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_dime_q <= sel_dime_d;
      jam_cnt_q  <= jam_cnt_d;
      coin_q     <= coin_d;
      reject_q   <= reject_d;
      jam_q      <= jam_d;
    end
  end

  assign coin   = coin_q;
  assign reject = reject_q;
  assign jam    = jam_q;
  assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios plus randomized insertions
// whose expected outputs are computed per insertion from timing arithmetic.
module tb_coin_acceptor;

  localparam int D   = 4;
  localparam int JAM = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       nickel_in = 1'b0;
  logic       dime_in = 1'b0;
  logic       enable = 1'b1;
  logic [1:0] coin;
  logic       reject;
  logic       jam;
  logic       busy;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  coin_acceptor #(
    .DEBOUNCE  (D),
    .JAM_LIMIT (JAM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .nickel_in (nickel_in),
    .dime_in   (dime_in),
    .enable    (enable),
    .coin      (coin),
    .reject    (reject),
    .jam       (jam),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int n, input logic [1:0] e_coin,
                            input logic e_rej, input logic e_busy, input logic e_jam);
    check($sformatf("%s coin n=%0d", tag, n), {30'd0, coin}, {30'd0, e_coin});
    check($sformatf("%s reject n=%0d", tag, n), {31'd0, reject}, {31'd0, e_rej});
    check($sformatf("%s busy n=%0d", tag, n), {31'd0, busy}, {31'd0, e_busy});
    check($sformatf("%s jam n=%0d", tag, n), {31'd0, jam}, {31'd0, e_jam});
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60 && busy; i++) step();
    check({tag, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  // kind: 0 nickel, 1 dime, 2 both rising together; h = raw cycles held high;
  // en_mode: 0/1 fixed enable, 2 enable randomized every cycle.
  task automatic run_insertion(input string tag, input int kind, input int h,
                               input int en_mode);
    int r, ev_n, busy_end, jam_n, total, n;
    logic ev_en;
    logic [1:0] code, e_coin;
    r = -1;
    ev_n = -1;
    ev_en = 1'b0;
    code = (kind == 1) ? 2'b10 : 2'b01;
    // r = edge entering release; lows only count on edges after r.
    if (kind == 2) begin
      r = 3;
      ev_n = 3;
      busy_end = ((h + 2 > 4) ? h + 2 : 4) + D;
    end else if (h >= D + 1) begin
      r = D + 3;
      ev_n = D + 3;
      busy_end = ((h + 2 > D + 4) ? h + 2 : D + 4) + D;
    end else begin
      busy_end = h + 3;
    end
    jam_n = (r > 0 && h + 1 - r >= JAM) ? r + JAM + 1 : -1;
    total = busy_end + 2;
    for (int k = 0; k < total; k++) begin
      n = k + 1;
      nickel_in = (k < h) && (kind != 1);
      dime_in   = (k < h) && (kind != 0);
      enable    = (en_mode == 2) ? 1'($urandom_range(0, 1)) : en_mode[0];
      if (k == ev_n - 1) ev_en = enable;
      step();
      e_coin = (n == ev_n && kind != 2 && ev_en) ? code : 2'b00;
      check_outs(tag, n, e_coin, (n == ev_n) && (kind == 2 || !ev_en),
                 (n >= 3) && (n < busy_end), (jam_n > 0) && (n >= jam_n) && (n < busy_end));
    end
  endtask

  initial begin
    int kind, h, mode;
    // Reset state
    #2;
    check_outs("reset", 0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    step();
    check_outs("post_reset", 0, 2'b00, 1'b0, 1'b0, 1'b0);

    run_insertion("nickel10", 0, 10, 1);
    run_insertion("dime_glitch3", 1, 3, 1);
    run_insertion("both_same_edge", 2, 6, 1);
    run_insertion("dime_min_qual", 1, D + 1, 1);
    run_insertion("nickel_max_glitch", 0, D, 1);
    run_insertion("dime_jam300", 1, 300, 0);

    // Nickel bounces during release: raw high 10 cycles, then alternates 8 cycles.
    for (int k = 0; k < 26; k++) begin
      nickel_in = (k < 10) ? 1'b1 : (k < 18) ? 1'(k % 2) : 1'b0;
      dime_in = 1'b0;
      enable = 1'b1;
      step();
      check_outs("bounce", k + 1, (k + 1 == 7) ? 2'b01 : 2'b00, 1'b0,
                 (k + 1 >= 3) && (k + 1 < 24), 1'b0);
    end

    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 2);
      h = $urandom_range(1, 2 * D + 6);
      mode = $urandom_range(0, 2);
      run_insertion($sformatf("rand%0d_k%0d_h%0d", t, kind, h), kind, h, mode);
    end

    // Reset during qualification (count=3) discards the coin.
    wait_idle("pre_rst_qual");
    enable = 1'b1;
    nickel_in = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check("rst_qual busy_before", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b0;
    nickel_in = 1'b0;
    #1;
    check_outs("rst_qual async", 0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check_outs("rst_qual after", k + 1, 2'b00, 1'b0, 1'b0, 1'b0);
    end

    // Sensor held through reset requalifies from scratch after release.
    nickel_in = 1'b1;
    for (int k = 0; k < 5; k++) step();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    for (int k = 0; k < D + 6; k++) begin
      step();
      check($sformatf("rst_held coin n=%0d", k + 1), {30'd0, coin},
            (k + 1 == D + 3) ? 32'd1 : 32'd0);
      check($sformatf("rst_held reject n=%0d", k + 1), {31'd0, reject}, 32'd0);
    end
    nickel_in = 1'b0;
    wait_idle("rst_held");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
